lsu_req_sched: RTL and testbench
================================

# lsu_req_sched

In-order scheduler between the two dual-issue lanes and the single load/store unit of the superscalar core. It accepts up to two `lsu_req_info_t` requests per cycle, with lane 0 older than lane 1, and buffers them in a small FIFO. It presents them to the LSU one at a time under a valid/ready handshake and caps the number of LSU transactions in flight. It sits between the issue stage and the LSU, and is emptied by the commit-flush path.

## Interface
- `Depth`, 4 — FIFO entries; power of 2, ≥ 2.
- `MaxOutst`, 2 — maximum LSU requests accepted but not yet completed; ≥ 1.

- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  2  per-lane request valid; lane 0 is older.
- `req_info_i`  in  2×`lsu_req_info_t`  per-lane request payload.
- `req_ready_o`  out  1  both lanes may enqueue this cycle.
- `lsu_req_valid_o`  out  1  request presented to the LSU.
- `lsu_req_info_o`  out  `lsu_req_info_t`  head payload.
- `lsu_req_ready_i`  in  1  LSU accepts the head.
- `lsu_done_i`  in  1  one outstanding LSU request completed.
- `flush_i`  in  1  discard all queued (not yet issued) requests.
- `count_o`  out  $clog2(Depth)+1  number of valid FIFO entries.
- `busy_o`  out  1  FIFO non-empty, or outstanding count > 0.

## Operation
- **Storage.** Circular FIFO with write pointer, read pointer and occupancy count, all registered.
- **Ready.** `req_ready_o` = (Depth − count) ≥ 2, computed from registered state only. It never depends on `lsu_req_ready_i` or `req_valid_i`.
- **Enqueue.** Happens when `req_ready_o` is high and at least one `req_valid_i` bit is set.
  - Both lanes valid: lane 0 is written at `wptr` and lane 1 at `wptr+1`.
  - Only one lane valid: that lane is written at `wptr`; lane 1 alone is legal.
  - `req_valid_i` while `req_ready_o` is low is ignored. The upstream stage holds the request.
- **Issue.**
  - `lsu_req_valid_o` = FIFO non-empty AND `outst_cnt < MaxOutst`, using the registered `outst_cnt`.
  - `lsu_req_info_o` is the entry at `rptr`.
  - The handshake (valid AND ready) pops one entry.
- **Outstanding counter** (`outst_cnt`, width $clog2(MaxOutst+1)).
  - +1 on handshake, −1 on `lsu_done_i`. Both in the same cycle leaves it unchanged.
  - `lsu_done_i` at count 0 is illegal: the counter holds, and an SVA flags it.
  - A `lsu_done_i` in cycle N unblocks issue only from cycle N+1.
- **Flush.**
  - `flush_i` clears count, `wptr` and `rptr` to 0 next cycle.
  - A same-cycle enqueue is dropped.
  - A same-cycle LSU handshake is honoured: the LSU keeps the request and `outst_cnt` increments.
  - `outst_cnt` is never cleared by flush; the LSU still signals done for in-flight requests.
- **Wrap-around.** Pointers are $clog2(Depth) bits and wrap naturally. Full/empty are taken from count, not from pointer compare.
- **Simultaneous events.** Pop and two-entry enqueue in the same cycle give count' = count + 2 − 1. The legality check uses the pre-pop count, so no bypass of freed slots.
- **Ordering.** Strictly in program order: older requests first, lane 0 before lane 1.

## Timing
- Reset values:
  - count, pointers and `outst_cnt` are 0.
  - `req_ready_o` = 1 (Depth ≥ 2).
  - `lsu_req_valid_o` = 0, `lsu_req_info_o` = `NULL_LSU_REQ_INFO`, `busy_o` = 0, `count_o` = 0.
- Reset mid-operation discards all entries and in-flight accounting. The LSU is reset in the same cycle.
- Latency from enqueue to `lsu_req_valid_o`:
  - Without bypass: 1 cycle.
  - With bypass: 0 cycles (see Configuration).
- Throughput: one LSU request per cycle while `outst_cnt < MaxOutst`.
- The payload is stable while `lsu_req_valid_o` is high and not yet accepted, except across a flush.

## Configuration
- **`KUDU_LSU_SCHED_BYPASS_EN` defined:**
  - When the FIFO is empty, `outst_cnt < MaxOutst`, `flush_i` is low and `req_ready_o` is high, the oldest valid lane is driven combinationally to `lsu_req_valid_o` / `lsu_req_info_o`.
  - If `lsu_req_ready_i` accepts it, that request is not written to the FIFO. Any younger lane is written at `wptr`.
- **Undefined:** every request passes through the FIFO, giving a minimum latency of 1 cycle. `lsu_req_valid_o` is then a function of registered state only.

## Structure
- `lsu_req_info_t` and `NULL_LSU_REQ_INFO` come from `super_pkg` (existing).
- Add to `super_pkg`: `LsuSchedDepth` (default 4) and `LsuSchedMaxOutst` (default 2), for top-level instantiation.
- One natural sub-module: `lsu_outst_cnt`, the saturating up/down in-flight counter with its SVA. The FIFO stays inline.

## Test plan
- **Dual enqueue, LSU always ready:** two `req_valid_i`=2'b11 with pcs 0x100/0x104. Issue order must be 0x100 then 0x104 on consecutive cycles; `outst_cnt` reaches 2; a third request stalls until `lsu_done_i`.
- **Fill to full with the LSU stalled (Depth=4):** after 2 dual enqueues, count_o=4, `req_ready_o`=0, and the count-3 case also has `req_ready_o`=0. Release the LSU; pop order matches enqueue order across pointer wrap.
- **Flush during activity:** count=3 with a same-cycle handshake and enqueue plus `flush_i`. Next cycle count_o=0; `outst_cnt` increments by 1; the dropped enqueue never appears at the LSU.
- **Done/issue collision:** `outst_cnt`=2 with `lsu_done_i` in cycle N. `lsu_req_valid_o` rises in N+1, not N; simultaneous handshake and done keep `outst_cnt` constant.
- **Lane 1 only:** `req_valid_i`=2'b10 with pc 0x200 is enqueued at entry 0 and issued next.
- **Bypass build, empty FIFO:** the request appears at the LSU in the same cycle. A ready LSU leaves count_o at 0; a stalled LSU leaves count_o at 1 next cycle.

Source files
------------

// File: rtl/super_pkg.sv
// super_pkg: shared types for the superscalar core's LSU request path.
//   lsu_req_info_t     - per-request payload handed from issue to the LSU
//   NULL_LSU_REQ_INFO  - idle payload value (all zero)
//   LsuSchedDepth      - default FIFO depth of lsu_req_sched
//   LsuSchedMaxOutst   - default in-flight cap of lsu_req_sched
package super_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic        is_store;
    logic [1:0]  size;
  } lsu_req_info_t;

  localparam lsu_req_info_t NULL_LSU_REQ_INFO = '0;

  localparam int LsuSchedDepth    = 4;
  localparam int LsuSchedMaxOutst = 2;

endpackage

// File: rtl/lsu_outst_cnt.sv
// lsu_outst_cnt: saturating up/down counter of LSU requests accepted but not
// yet completed.
//   clk_i, rst_i  clock, synchronous active-high reset
//   inc_i         LSU handshake this cycle
//   dec_i         LSU completion this cycle
//   cnt_o         registered in-flight count
// A completion at count 0 is a protocol error: the counter holds and the
// assertion below fires.
module lsu_outst_cnt #(
  parameter int MaxOutst = 2,
  parameter int OW       = $clog2(MaxOutst + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [OW-1:0] cnt_o
);

  logic [OW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      unique case ({inc_i, dec_i})
        2'b10:   if (r_cnt != OW'(MaxOutst)) r_cnt <= r_cnt + 1'b1;
        2'b01:   if (r_cnt != '0)            r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;  // idle, or issue and completion cancel
      endcase
    end
  end

  assign cnt_o = r_cnt;

  a_done_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(dec_i && !inc_i && r_cnt == '0));

endmodule

// File: rtl/lsu_req_sched.sv
// lsu_req_sched: in-order scheduler from the two issue lanes into the single
// LSU. Up to two requests per cycle go into a circular FIFO (lane 0 older);
// the head is offered to the LSU under valid/ready, capped at MaxOutst
// requests in flight.
//   clk_i, rst_i       clock, synchronous active-high reset
//   req_valid_i/info_i per-lane request (lane 0 older)
//   req_ready_o        at least two free FIFO slots (both lanes may enqueue)
//   lsu_req_*          head request to the LSU, valid/ready
//   lsu_done_i         one in-flight LSU request completed
//   flush_i            drop every queued (not yet issued) request
//   count_o            FIFO occupancy
//   busy_o             FIFO non-empty or requests in flight
// Optional feature macro: KUDU_LSU_SCHED_BYPASS_EN - an empty FIFO forwards
// the oldest valid lane straight to the LSU in the same cycle.
module lsu_req_sched
  import super_pkg::*;
#(
  parameter int Depth    = LsuSchedDepth,
  parameter int MaxOutst = LsuSchedMaxOutst,
  parameter int PW       = $clog2(Depth),
  parameter int CW       = $clog2(Depth) + 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          req_valid_i,
  input  lsu_req_info_t [1:0] req_info_i,
  output logic                req_ready_o,
  output logic                lsu_req_valid_o,
  output lsu_req_info_t       lsu_req_info_o,
  input  logic                lsu_req_ready_i,
  input  logic                lsu_done_i,
  input  logic                flush_i,
  output logic [CW-1:0]       count_o,
  output logic                busy_o
);

  localparam int OW = $clog2(MaxOutst + 1);

  lsu_req_info_t r_mem [Depth];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;

  logic [OW-1:0] w_outst;
  logic          w_nonempty, w_cnt_ok, w_hs, w_pop, w_byp;
  logic [1:0]    w_wr_vld;
  logic [1:0]    w_wr_n;
  logic [PW-1:0] w_wptr1;
  lsu_req_info_t w_byp_info;

  // Ready looks only at registered occupancy; the pre-pop count is used so
  // a slot freed this cycle is not reused until next cycle.
  assign req_ready_o = (r_count <= CW'(Depth - 2));
  assign w_nonempty  = (r_count != '0);
  assign w_cnt_ok    = (w_outst < OW'(MaxOutst));
  assign w_wptr1     = r_wptr + 1'b1;

`ifdef KUDU_LSU_SCHED_BYPASS_EN
  assign w_byp      = !w_nonempty && w_cnt_ok && !flush_i && req_ready_o && (|req_valid_i);
  assign w_byp_info = req_valid_i[0] ? req_info_i[0] : req_info_i[1];
`else
  assign w_byp      = 1'b0;
  assign w_byp_info = NULL_LSU_REQ_INFO;
`endif

  always_comb begin
    lsu_req_valid_o = (w_nonempty && w_cnt_ok) || w_byp;
    lsu_req_info_o  = NULL_LSU_REQ_INFO;
    if (w_nonempty)  lsu_req_info_o = r_mem[r_rptr];
    else if (w_byp)  lsu_req_info_o = w_byp_info;
  end

  assign w_hs  = lsu_req_valid_o && lsu_req_ready_i;
  // A bypassed handshake never touched the FIFO, so it pops nothing.
  assign w_pop = w_hs && !w_byp;

  // Lanes actually written: gated by ready and flush, minus the oldest lane
  // when it went straight to the LSU.
  always_comb begin
    w_wr_vld = (req_ready_o && !flush_i) ? req_valid_i : 2'b00;
    if (w_byp && lsu_req_ready_i) begin
      if (w_wr_vld[0]) w_wr_vld[0] = 1'b0;
      else             w_wr_vld[1] = 1'b0;
    end
    w_wr_n = {1'b0, w_wr_vld[0]} + {1'b0, w_wr_vld[1]};
  end

  // Payload storage needs no reset; occupancy decides what is live.
  always_ff @(posedge clk_i) begin
    if (w_wr_vld == 2'b11) begin
      r_mem[r_wptr]  <= req_info_i[0];
      r_mem[w_wptr1] <= req_info_i[1];
    end else if (w_wr_vld[0]) begin
      r_mem[r_wptr]  <= req_info_i[0];
    end else if (w_wr_vld[1]) begin
      r_mem[r_wptr]  <= req_info_i[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + PW'(w_wr_n);
      r_rptr  <= r_rptr + PW'(w_pop);
      r_count <= r_count + CW'(w_wr_n) - CW'(w_pop);
    end
  end

  // Flush does not touch this: the LSU still completes what it accepted.
  lsu_outst_cnt #(.MaxOutst(MaxOutst), .OW(OW)) u_outst (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_hs),
    .dec_i (lsu_done_i),
    .cnt_o (w_outst)
  );

  assign count_o = r_count;
  assign busy_o  = w_nonempty || (w_outst != '0);

endmodule

// File: tb/tb_lsu_req_sched.sv
module tb_lsu_req_sched;
  import super_pkg::*;

  logic                clk, rst;
  logic [1:0]          req_valid;
  lsu_req_info_t [1:0] req_info;
  logic                req_ready;
  logic                lsu_vld;
  lsu_req_info_t       lsu_info;
  logic                lsu_rdy, done, flush;
  logic [2:0]          count;
  logic                busy;

  int n_chk = 0;
  int n_bad = 0;

  lsu_req_sched #(.Depth(4), .MaxOutst(2)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_info_i      (req_info),
    .req_ready_o     (req_ready),
    .lsu_req_valid_o (lsu_vld),
    .lsu_req_info_o  (lsu_info),
    .lsu_req_ready_i (lsu_rdy),
    .lsu_done_i      (done),
    .flush_i         (flush),
    .count_o         (count),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic lsu_req_info_t mk(input logic [31:0] pc);
    lsu_req_info_t r;
    r          = '0;
    r.pc       = pc;
    r.addr     = pc ^ 32'h1000_0000;
    r.is_store = pc[2];
    r.size     = 2'b10;
    return r;
  endfunction

  // One clock: inputs driven before the call are sampled on the posedge,
  // then cleared; returns at the following negedge for checking.
  task automatic cyc();
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    req_info  = '0;
    lsu_rdy   = 1'b0;
    done      = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_info = '0;
    lsu_rdy = 1'b0; done = 1'b0; flush = 1'b0;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_vld",   32'(lsu_vld), 0);
    chk("rst_info",  32'(lsu_info.pc), 0);
    chk("rst_busy",  32'(busy), 0);
    rst = 1'b0;
    cyc();

    // Dual enqueue, issue in order, cap at two in flight
    req_valid = 2'b11; req_info[0] = mk(32'h100); req_info[1] = mk(32'h104); cyc();
    chk("t1_cnt2", 32'(count), 2);
    chk("t1_vld",  32'(lsu_vld), 1);
    chk("t1_hd0",  lsu_info.pc, 32'h100);
    chk("t1_addr", lsu_info.addr, 32'h1000_0100);
    lsu_rdy = 1'b1; cyc();
    chk("t1_hd1",  lsu_info.pc, 32'h104);
    chk("t1_out1", 32'(dut.w_outst), 1);
    lsu_rdy = 1'b1; cyc();
    chk("t1_out2", 32'(dut.w_outst), 2);
    chk("t1_empty_vld", 32'(lsu_vld), 0);
    req_valid = 2'b01; req_info[0] = mk(32'h108); cyc();
    chk("t1_stall_cnt", 32'(count), 1);
    chk("t1_stall_vld", 32'(lsu_vld), 0);
    done = 1'b1;
    chk("t1_doneN_vld", 32'(lsu_vld), 0);
    cyc();
    chk("t1_doneN1_vld", 32'(lsu_vld), 1);
    chk("t1_hd2", lsu_info.pc, 32'h108);
    lsu_rdy = 1'b1; done = 1'b1; cyc();
    chk("t1_hsdone_out", 32'(dut.w_outst), 1);
    chk("t1_hsdone_cnt", 32'(count), 0);
    chk("t1_busy1", 32'(busy), 1);
    done = 1'b1; cyc();
    chk("t1_out0", 32'(dut.w_outst), 0);
    chk("t1_busy0", 32'(busy), 0);

    // Fill to full with LSU stalled, then drain across pointer wrap
    req_valid = 2'b11; req_info[0] = mk(32'h300); req_info[1] = mk(32'h304); cyc();
    chk("t2_cnt2", 32'(count), 2);
    chk("t2_rdy2", 32'(req_ready), 1);
    req_valid = 2'b11; req_info[0] = mk(32'h308); req_info[1] = mk(32'h30c); cyc();
    chk("t2_cnt4", 32'(count), 4);
    chk("t2_rdy4", 32'(req_ready), 0);
    chk("t2_hd_a", lsu_info.pc, 32'h300);
    req_valid = 2'b11; req_info[0] = mk(32'h900); req_info[1] = mk(32'h904); cyc();
    chk("t2_ign_cnt", 32'(count), 4);
    chk("t2_hd_b", lsu_info.pc, 32'h300);
    lsu_rdy = 1'b1; cyc();
    chk("t2_cnt3", 32'(count), 3);
    chk("t2_rdy3", 32'(req_ready), 0);
    chk("t2_pop1", lsu_info.pc, 32'h304);
    lsu_rdy = 1'b1; done = 1'b1; cyc();
    chk("t2_pop2", lsu_info.pc, 32'h308);
    chk("t2_rdy2b", 32'(req_ready), 1);
    lsu_rdy = 1'b1; done = 1'b1; cyc();
    chk("t2_pop3", lsu_info.pc, 32'h30c);
    lsu_rdy = 1'b1; done = 1'b1; cyc();
    chk("t2_drained", 32'(count), 0);
    chk("t2_vld0", 32'(lsu_vld), 0);
    done = 1'b1; cyc();
    chk("t2_busy0", 32'(busy), 0);

    // Flush with same-cycle handshake and enqueue
    req_valid = 2'b11; req_info[0] = mk(32'h400); req_info[1] = mk(32'h404); cyc();
    req_valid = 2'b01; req_info[0] = mk(32'h408); cyc();
    chk("t3_cnt3", 32'(count), 3);
    chk("t3_hd", lsu_info.pc, 32'h400);
    lsu_rdy = 1'b1; flush = 1'b1;
    req_valid = 2'b11; req_info[0] = mk(32'hbad0); req_info[1] = mk(32'hbad4); cyc();
    chk("t3_fl_cnt", 32'(count), 0);
    chk("t3_fl_out", 32'(dut.w_outst), 1);
    chk("t3_fl_vld", 32'(lsu_vld), 0);
    chk("t3_fl_rdy", 32'(req_ready), 1);
    done = 1'b1; cyc();
    flush = 1'b1; req_valid = 2'b11; req_info[0] = mk(32'h500); req_info[1] = mk(32'h504); cyc();
    chk("t3_drop_cnt", 32'(count), 0);
    chk("t3_drop_vld", 32'(lsu_vld), 0);

    // Lane 1 only lands at entry 0 after the flush
    req_valid = 2'b10; req_info[0] = mk(32'hdead); req_info[1] = mk(32'h200); cyc();
    chk("t4_cnt1", 32'(count), 1);
    chk("t4_vld", 32'(lsu_vld), 1);
    chk("t4_hd", lsu_info.pc, 32'h200);
    chk("t4_mem0", dut.r_mem[0].pc, 32'h200);
    lsu_rdy = 1'b1; cyc();
    chk("t4_cnt0", 32'(count), 0);
    chk("t4_out1", 32'(dut.w_outst), 1);
    done = 1'b1; cyc();
    chk("t4_busy0", 32'(busy), 0);

`ifdef KUDU_LSU_SCHED_BYPASS_EN
    // Empty FIFO forwards the request in the same cycle
    req_valid = 2'b01; req_info[0] = mk(32'h600); lsu_rdy = 1'b1;
    #1;
    chk("t5_byp_vld", 32'(lsu_vld), 1);
    chk("t5_byp_pc", lsu_info.pc, 32'h600);
    cyc();
    chk("t5_byp_cnt", 32'(count), 0);
    chk("t5_byp_out", 32'(dut.w_outst), 1);
    req_valid = 2'b01; req_info[0] = mk(32'h604);
    #1;
    chk("t5_stl_vld", 32'(lsu_vld), 1);
    cyc();
    chk("t5_stl_cnt", 32'(count), 1);
    lsu_rdy = 1'b1; cyc();
    done = 1'b1; cyc();
    done = 1'b1; cyc();
    chk("t5_busy0", 32'(busy), 0);
`else
    // Without bypass the request needs one cycle in the FIFO
    req_valid = 2'b01; req_info[0] = mk(32'h600); lsu_rdy = 1'b1;
    #1;
    chk("t5_nobyp_vld", 32'(lsu_vld), 0);
    cyc();
    chk("t5_nobyp_cnt", 32'(count), 1);
    chk("t5_nobyp_pc", lsu_info.pc, 32'h600);
    lsu_rdy = 1'b1; cyc();
    done = 1'b1; cyc();
    chk("t5_busy0", 32'(busy), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
